// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   Bus master for the shared-tristate word memory. Takes single-word
//   read/write requests on a valid/ready front end, runs one memory bus
//   cycle per request and returns the result on a valid/ready response
//   channel. Misaligned or out-of-range requests are answered with an
//   error and never touch the memory bus.
//
//   Handshakes: a transfer happens on the posedge of phi1 where both valid
//   and ready are 1. The response side holds rsp_valid/rsp_rdata/rsp_err
//   stable until that edge. Request fields are only looked at in IDLE.
//
// Ports
//   phi1, resetn        clock (posedge) and asynchronous active-low reset
//   req_valid/ready     request handshake
//   req_write           1 = write, 0 = read
//   req_addr            byte address (must be word aligned)
//   req_wdata           write data
//   rsp_valid/ready     response handshake
//   rsp_rdata           read data (0 for writes and errors)
//   rsp_err             request rejected
//   mem_addr            memory address bus, changes only on accept
//   mem_r, mem_w        memory strobes, never both high
//   mem_data            bidirectional data, driven only while mem_w = 1
//   txn_count           completed-response counter (wraps)
//   dbg_state           current FSM state for observation
module mem_bus_initiator #(
   parameter int ADDR_W    = 26,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 81920,
   parameter int READ_WAIT = 2
) (
   input  logic              phi1,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_r,
   output logic              mem_w,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic [15:0]       txn_count,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_t;

   // Counter is loaded with READ_WAIT-1 so mem_r spans READ_WAIT cycles.
   localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

   state_t              state_q, state_n;
   logic                ready_q, ready_n;
   logic                rsp_valid_q, rsp_valid_n;
   logic                rsp_err_q, rsp_err_n;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic                mem_r_q, mem_r_n;
   logic                mem_w_q, mem_w_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n;
   logic [3:0]          wait_q, wait_n;
   logic [15:0]         txn_q, txn_n;
   logic                addr_err;

   assign addr_err = (req_addr[1:0] != 2'b00) ||
                     (32'(req_addr[ADDR_W-1:2]) >= 32'(MEM_WORDS));

   always_comb begin
      state_n     = state_q;
      ready_n     = ready_q;
      rsp_valid_n = rsp_valid_q;
      rsp_err_n   = rsp_err_q;
      rsp_rdata_n = rsp_rdata_q;
      addr_n      = addr_q;
      mem_r_n     = mem_r_q;
      mem_w_n     = mem_w_q;
      wdata_n     = wdata_q;
      wait_n      = wait_q;
      txn_n       = txn_q;
      case (state_q)
         IDLE: begin
            // ready_q is 0 for the first cycle after reset release, so the
            // earliest accept is one edge later.
            if (req_valid && ready_q) begin
               ready_n = 1'b0;
               if (addr_err) begin
                  state_n     = RESP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
               end else if (req_write) begin
                  state_n = WR;
                  addr_n  = req_addr;
                  mem_w_n = 1'b1;
                  wdata_n = req_wdata;
               end else begin
                  state_n = RD;
                  addr_n  = req_addr;
                  mem_r_n = 1'b1;
                  wait_n  = WAIT_INIT;
               end
            end else begin
               ready_n = 1'b1;
            end
         end
         WR: begin
            // Memory samples the data on this edge; release the bus here.
            mem_w_n     = 1'b0;
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
         end
         RD: begin
            if (wait_q == 4'd0) begin
               rsp_rdata_n = mem_data;
               mem_r_n     = 1'b0;
               state_n     = RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
            end else begin
               wait_n = wait_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n     = IDLE;
               ready_n     = 1'b1;
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = '0;
               txn_n       = txn_q + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge phi1 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         mem_r_q     <= 1'b0;
         mem_w_q     <= 1'b0;
         wdata_q     <= '0;
         wait_q      <= '0;
         txn_q       <= '0;
      end else begin
         state_q     <= state_n;
         ready_q     <= ready_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_err_q   <= rsp_err_n;
         rsp_rdata_q <= rsp_rdata_n;
         addr_q      <= addr_n;
         mem_r_q     <= mem_r_n;
         mem_w_q     <= mem_w_n;
         wdata_q     <= wdata_n;
         wait_q      <= wait_n;
         txn_q       <= txn_n;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = addr_q;
   assign mem_r     = mem_r_q;
   assign mem_w     = mem_w_q;
   assign txn_count = txn_q;
   assign dbg_state = state_q;

   // Drive enable is the registered write strobe itself.
   assign mem_data = mem_w_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: test memory on the tristate bus, a
// transaction-timeline model of the expected outputs, a per-cycle compare
// process and directed scenarios with literal expectations.
module tb_mem_bus_initiator;

   localparam int RW        = 3;
   localparam int MEM_WORDS = 81920;
   localparam logic [1:0] KE = 2'd0, KW = 2'd1, KR = 2'd2;

   logic        phi1 = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [25:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [25:0] mem_addr;
   logic        mem_r;
   logic        mem_w;
   wire  [31:0] mem_data;
   logic [15:0] txn_count;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   mem_bus_initiator #(
      .ADDR_W(26), .DATA_W(32), .MEM_WORDS(MEM_WORDS), .READ_WAIT(RW)
   ) dut (
      .phi1(phi1), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w),
      .mem_data(mem_data), .txn_count(txn_count), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 phi1 = ~phi1;

   // ---------------- test memory ----------------
   logic [31:0] pmem [0:1023];
   assign mem_data = mem_r ? pmem[mem_addr[11:2]] : 32'bz;
   always @(posedge phi1) if (mem_w) pmem[mem_addr[11:2]] <= mem_data;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A transaction is described by its kind and k = cycles since the accept
   // edge. Writes strobe at k=1 and respond at k=2, reads strobe for k=1..RW
   // and respond at k=RW+1, errors respond at k=1.
   logic        m_active = 1'b0, m_armed = 1'b0;
   logic [1:0]  m_kind = KE;
   int          m_k = 0;
   logic [25:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_rdata = '0;
   logic [15:0] m_cnt = '0;
   logic [31:0] mm [0:4095];

   function automatic int lat_of(input logic [1:0] kind);
      case (kind)
         KW:      return 2;
         KR:      return RW + 1;
         default: return 1;
      endcase
   endfunction

   always @(posedge phi1 or negedge resetn) begin
      if (!resetn) begin
         m_active <= 1'b0; m_armed <= 1'b0; m_k <= 0;
         m_addr <= '0; m_cnt <= '0;
      end else begin
         m_armed <= 1'b1;
         if (m_active) begin
            if (m_k >= lat_of(m_kind) && rsp_ready) begin
               m_active <= 1'b0;
               m_cnt    <= m_cnt + 16'd1;
            end else begin
               if (m_kind == KW && m_k == 1) mm[m_addr[13:2]] <= m_wdata;
               if (m_k < lat_of(m_kind)) m_k <= m_k + 1;
            end
         end else if (m_armed && req_valid) begin
            m_active <= 1'b1;
            m_k      <= 1;
            if (req_addr[1:0] != 2'b00 || 32'(req_addr[25:2]) >= 32'(MEM_WORDS)) begin
               m_kind <= KE; m_rdata <= '0;
            end else if (req_write) begin
               m_kind <= KW; m_addr <= req_addr; m_wdata <= req_wdata; m_rdata <= '0;
            end else begin
               m_kind <= KR; m_addr <= req_addr; m_rdata <= mm[req_addr[13:2]];
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic cmp_on = 1'b0;
   logic e_rv, e_w, e_r;
   always @(negedge phi1) begin
      if (cmp_on) begin
         e_rv = m_active && (m_k >= lat_of(m_kind));
         e_w  = m_active && (m_kind == KW) && (m_k == 1);
         e_r  = m_active && (m_kind == KR) && (m_k >= 1) && (m_k <= RW);
         chk("req_ready", 32'(req_ready), 32'(m_armed && !m_active));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("mem_w", 32'(mem_w), 32'(e_w));
         chk("mem_r", 32'(mem_r), 32'(e_r));
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("txn_count", 32'(txn_count), 32'(m_cnt));
         chk("strobe_excl", 32'(mem_r & mem_w), 32'd0);
         if (e_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(m_kind == KE));
         end
         if (e_w) chk("mem_data_wr", mem_data, m_wdata);
         if (!resetn) begin
            chk("rst_rdata", rsp_rdata, 32'd0);
            chk("rst_err", 32'(rsp_err), 32'd0);
         end
      end
   end

   // ---------------- strobe pulse monitor ----------------
   int w_run = 0, r_run = 0, last_w_len = 0, last_r_len = 0;
   int w_pulses = 0, r_pulses = 0;
   logic [31:0] w_data_seen = '0;
   always @(negedge phi1) begin
      if (mem_w) begin
         w_run <= w_run + 1; w_data_seen <= mem_data;
      end else if (w_run != 0) begin
         last_w_len <= w_run; w_pulses <= w_pulses + 1; w_run <= 0;
      end
      if (mem_r) r_run <= r_run + 1;
      else if (r_run != 0) begin
         last_r_len <= r_run; r_pulses <= r_pulses + 1; r_run <= 0;
      end
   end

   // ---------------- driver tasks ----------------
   // Returns at the negedge right after the accepting posedge.
   task automatic send(input logic wr, input logic [25:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge phi1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      while (!req_ready && n < 50) begin @(negedge phi1); n++; end
      chk("req_accept", 32'(req_ready), 32'd1);
      @(negedge phi1);
      req_valid = 1'b0;
   endtask

   // Waits for rsp_valid (rsp_ready high), reports cycles since accept,
   // returns after the handshake edge.
   task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
      int n;
      n = 1;
      while (!rsp_valid && n < 40) begin @(negedge phi1); n++; end
      chk("rsp_arrive", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; er = rsp_err; lat = n;
      @(negedge phi1);
   endtask

   task automatic do_txn(input logic wr, input logic [25:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat);
      send(wr, a, d);
      wait_rsp(rd, er, lat);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   logic [31:0] rd;
   logic        er;
   int          lat, wp0, rp0;

   initial begin
      for (int i = 0; i < 1024; i++) pmem[i] = '0;
      for (int i = 0; i < 4096; i++) mm[i] = '0;

      // Reset values
      repeat (3) @(negedge phi1);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_rw", 32'({mem_r, mem_w}), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      cmp_on = 1'b1;
      resetn = 1'b1;
      repeat (2) @(negedge phi1);
      chk("idle_ready", 32'(req_ready), 32'd1);

      // Write then read back
      do_txn(1'b1, 26'h000010, 32'hDEADBEEF, rd, er, lat);
      chk("wr_lat", 32'(lat), 32'd2);
      chk("wr_err", 32'(er), 32'd0);
      chk("wr_pulse_len", 32'(last_w_len), 32'd1);
      chk("wr_bus_data", w_data_seen, 32'hDEADBEEF);
      do_txn(1'b0, 26'h000010, 32'h0, rd, er, lat);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_err", 32'(er), 32'd0);
      chk("rd_lat", 32'(lat), 32'(RW + 1));
      chk("rd_pulse_len", 32'(last_r_len), 32'(RW));
      chk("txn_after_2", 32'(txn_count), 32'd2);

      // Error requests: misaligned, first word out of range; last valid word
      wp0 = w_pulses; rp0 = r_pulses;
      do_txn(1'b1, 26'h000012, 32'h55555555, rd, er, lat);
      chk("mis_err", 32'(er), 32'd1);
      chk("mis_rdata", rd, 32'd0);
      chk("mis_lat", 32'(lat), 32'd1);
      do_txn(1'b0, 26'h050000, 32'h0, rd, er, lat);
      chk("oor_err", 32'(er), 32'd1);
      chk("oor_rdata", rd, 32'd0);
      chk("err_no_strobe", 32'((w_pulses - wp0) + (r_pulses - rp0) + w_run + r_run), 32'd0);
      do_txn(1'b0, 26'h04FFFC, 32'h0, rd, er, lat);
      chk("last_word_err", 32'(er), 32'd0);
      chk("txn_after_5", 32'(txn_count), 32'd5);

      // Response back-pressure with an ignored request meanwhile
      do_txn(1'b1, 26'h000040, 32'h12345678, rd, er, lat);
      rsp_ready = 1'b0;
      send(1'b0, 26'h000040, 32'h0);
      for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge phi1);
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, 32'h12345678);
         chk("hold_ready", 32'(req_ready), 32'd0);
         req_valid = 1'b1; req_write = 1'b1; req_addr = 26'h000040; req_wdata = 32'hBAD0BAD0;
         @(negedge phi1);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge phi1);
      chk("hold_txn", 32'(txn_count), 32'd7);
      do_txn(1'b0, 26'h000040, 32'h0, rd, er, lat);
      chk("ignored_wr", rd, 32'h12345678);

      // Reset in the middle of a read
      send(1'b0, 26'h000010, 32'h0);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_mem_r", 32'(mem_r), 32'd0);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_txn", 32'(txn_count), 32'd0);
      repeat (2) @(negedge phi1);
      resetn = 1'b1;
      repeat (2) @(negedge phi1);
      do_txn(1'b0, 26'h000010, 32'h0, rd, er, lat);
      chk("post_rst_rd", rd, 32'hDEADBEEF);
      chk("post_rst_txn", 32'(txn_count), 32'd1);

      // Reset during the write strobe: write must not land
      send(1'b1, 26'h000020, 32'h11111111);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_mem_w", 32'(mem_w), 32'd0);
      repeat (2) @(negedge phi1);
      resetn = 1'b1;
      repeat (2) @(negedge phi1);
      do_txn(1'b0, 26'h000020, 32'h0, rd, er, lat);
      chk("aborted_wr", rd, 32'd0);

      // Counter wrap
      for (int i = 0; i < 20; i++) do_txn(1'b0, 26'h000003, 32'h0, rd, er, lat);
      chk("txn_21", 32'(txn_count), 32'd21);
      @(negedge phi1);
      force dut.txn_q = 16'hFFFD;
      m_cnt = 16'hFFFD;
      #1 release dut.txn_q;
      for (int i = 0; i < 2; i++) do_txn(1'b1, 26'h3FFFFFC, 32'h0, rd, er, lat);
      chk("txn_ffff", 32'(txn_count), 32'h0000FFFF);
      do_txn(1'b1, 26'h000001, 32'h0, rd, er, lat);
      chk("txn_wrap", 32'(txn_count), 32'd0);

      repeat (3) @(negedge phi1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
